// File: rtl/match_round_if.sv
// Handshake bundle between the match sequencer and the game blocks it gates.
// The master modport belongs to whoever drives the tick, health and buttons.
interface match_round_if #(
  parameter int HP_W    = 9,
  parameter int SCORE_W = 2
);
  logic               tick_en;
  logic [HP_W-1:0]    health_1;
  logic [HP_W-1:0]    health_2;
  logic               confirm_btn;
  logic               force_reset_sw;
  logic               inputs_enable;
  logic               round_reset;
  logic [3:0]         round_num;
  logic [6:0]         timer_secs;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic [1:0]         winner;
  logic               match_over;
  logic [1:0]         state_dbg;

  modport master (
    output tick_en, health_1, health_2, confirm_btn, force_reset_sw,
    input  inputs_enable, round_reset, round_num, timer_secs,
    input  score_1, score_2, winner, match_over, state_dbg
  );

  modport slave (
    input  tick_en, health_1, health_2, confirm_btn, force_reset_sw,
    output inputs_enable, round_reset, round_num, timer_secs,
    output score_1, score_2, winner, match_over, state_dbg
  );
endinterface

// File: rtl/match_round_controller.sv
// Best-of-N match sequencer: intro countdown, timed fight, result display,
// scoring, match winner and hold-to-restart (confirm or force switch).
module match_round_controller #(
  parameter int HP_W          = 9,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_SECS    = 60,
  parameter int TICK_HZ       = 20,
  parameter int READY_TICKS   = 60,
  parameter int RESULT_TICKS  = 40,
  parameter int HOLD_TICKS    = 40,
  parameter int SCORE_W       = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic         clk,
  input  logic         reset,
  match_round_if.slave bus
);

  localparam int CNT_MAX = (READY_TICKS > RESULT_TICKS) ? READY_TICKS : RESULT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUB_W   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

  localparam logic [CNT_W-1:0]   READY_C  = CNT_W'(READY_TICKS);
  localparam logic [CNT_W-1:0]   RESULT_C = CNT_W'(RESULT_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(TICK_HZ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_C   = HOLD_W'(HOLD_TICKS);
  localparam logic [6:0]         ROUND_C  = 7'(ROUND_SECS);
  localparam logic [SCORE_W-1:0] WIN_C    = SCORE_W'(ROUNDS_TO_WIN);

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  typedef enum logic [1:0] {
    S_INTRO      = 2'd0,
    S_FIGHT      = 2'd1,
    S_ROUND_END  = 2'd2,
    S_MATCH_OVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [6:0]         timer_q, timer_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [3:0]         round_q, round_d;
  logic [1:0]         winner_q, winner_d;
  logic               ien_q, ien_d, rr_q, rr_d, mo_q, mo_d;
  logic [HOLD_W-1:0]  chold_q, chold_d, fhold_q, fhold_d;
  logic               clock_q, clock_d, flock_q, flock_d;

  logic       restart, pulse, decide, h1_zero, h2_zero;
  logic [1:0] res;

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
    return (h == HOLD_C) ? h : h + HOLD_W'(1);
  endfunction

  function automatic logic [3:0] round_inc(input logic [3:0] r);
    return (r == 4'd15) ? r : r + 4'd1;
  endfunction

  assign h1_zero = (bus.health_1 == '0);
  assign h2_zero = (bus.health_2 == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    timer_d  = timer_q;
    score1_d = score1_q;
    score2_d = score2_q;
    round_d  = round_q;
    winner_d = winner_q;
    ien_d    = ien_q;
    mo_d     = mo_q;
    chold_d  = chold_q;
    fhold_d  = fhold_q;
    clock_d  = clock_q;
    flock_d  = flock_q;
    restart  = 1'b0;
    pulse    = 1'b0;
    decide   = 1'b0;
    res      = W_NONE;

    if (bus.tick_en) begin
      // A lock is taken at each restart so a still-held button cannot retrigger.
      if (!bus.force_reset_sw) begin
        fhold_d = '0;
        flock_d = 1'b0;
      end else if (!flock_q) begin
        fhold_d = hold_inc(fhold_q);
      end

      if (!bus.confirm_btn) begin
        chold_d = '0;
        clock_d = 1'b0;
      end else if (state_q != S_MATCH_OVER) begin
        chold_d = '0;
      end else if (!clock_q) begin
        chold_d = hold_inc(chold_q);
      end

      restart = (fhold_d == HOLD_C) ||
                ((state_q == S_MATCH_OVER) && (chold_d == HOLD_C));

      if (restart) begin
        state_d  = S_INTRO;
        cnt_d    = READY_C;
        sub_d    = '0;
        timer_d  = ROUND_C;
        score1_d = '0;
        score2_d = '0;
        round_d  = 4'd1;
        winner_d = W_NONE;
        ien_d    = 1'b0;
        mo_d     = 1'b0;
        chold_d  = '0;
        fhold_d  = '0;
        flock_d  = bus.force_reset_sw;
        clock_d  = bus.confirm_btn;
        pulse    = 1'b1;
      end else begin
        unique case (state_q)
          S_INTRO: begin
            if (cnt_q == CNT_ONE) begin
              state_d = S_FIGHT;
              timer_d = ROUND_C;
              sub_d   = '0;
              ien_d   = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          S_FIGHT: begin
            if (h1_zero && h2_zero) begin
              decide = 1'b1;
              res    = W_DRAW;
            end else if (h1_zero) begin
              decide = 1'b1;
              res    = W_P2;
            end else if (h2_zero) begin
              decide = 1'b1;
              res    = W_P1;
            end else if (sub_q == SUB_LAST) begin
              sub_d   = '0;
              timer_d = timer_q - 7'd1;
              if (timer_q == 7'd1) begin
                decide = 1'b1;
                res    = (bus.health_1 > bus.health_2) ? W_P1 :
                         (bus.health_2 > bus.health_1) ? W_P2 : W_DRAW;
              end
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
            if (decide) begin
              winner_d = res;
              if (res == W_P1) score1_d = score1_q + SCORE_W'(1);
              if (res == W_P2) score2_d = score2_q + SCORE_W'(1);
              state_d = S_ROUND_END;
              cnt_d   = RESULT_C;
              ien_d   = 1'b0;
            end
          end
          S_ROUND_END: begin
            if (cnt_q == CNT_ONE) begin
              if ((score1_q == WIN_C) || (score2_q == WIN_C)) begin
                state_d  = S_MATCH_OVER;
                mo_d     = 1'b1;
                winner_d = (score1_q == WIN_C) ? W_P1 : W_P2;
              end else begin
                state_d  = S_INTRO;
                round_d  = round_inc(round_q);
                winner_d = W_NONE;
                cnt_d    = READY_C;
                pulse    = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end

    rr_d = pulse && !rr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_INTRO;
      cnt_q    <= READY_C;
      sub_q    <= '0;
      timer_q  <= ROUND_C;
      score1_q <= '0;
      score2_q <= '0;
      round_q  <= 4'd1;
      winner_q <= W_NONE;
      ien_q    <= 1'b0;
      rr_q     <= 1'b0;
      mo_q     <= 1'b0;
      chold_q  <= '0;
      fhold_q  <= '0;
      clock_q  <= 1'b0;
      flock_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      timer_q  <= timer_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      round_q  <= round_d;
      winner_q <= winner_d;
      ien_q    <= ien_d;
      rr_q     <= rr_d;
      mo_q     <= mo_d;
      chold_q  <= chold_d;
      fhold_q  <= fhold_d;
      clock_q  <= clock_d;
      flock_q  <= flock_d;
    end
  end

  assign bus.inputs_enable = ien_q;
  assign bus.round_reset   = rr_q;
  assign bus.round_num     = round_q;
  assign bus.timer_secs    = timer_q;
  assign bus.score_1       = score1_q;
  assign bus.score_2       = score2_q;
  assign bus.winner        = winner_q;
  assign bus.match_over    = mo_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_match_round_controller.sv
// Bench for match_round_controller: directed test-plan steps plus random play,
// every cycle compared against an event-level model of the match rules.
module tb_match_round_controller;
  localparam int HP_W   = 9;
  localparam int R_WIN  = 2;
  localparam int SECS   = 60;
  localparam int HZ     = 20;
  localparam int READY  = 60;
  localparam int RESULT = 40;
  localparam int HOLD   = 40;
  localparam int SW     = $clog2(R_WIN + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  match_round_if #(.HP_W(HP_W), .SCORE_W(SW)) bus ();

  match_round_controller #(
    .HP_W(HP_W), .ROUNDS_TO_WIN(R_WIN), .ROUND_SECS(SECS), .TICK_HZ(HZ),
    .READY_TICKS(READY), .RESULT_TICKS(RESULT), .HOLD_TICKS(HOLD), .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 intro, 1 fight, 2 result, 3 match over; progress kept as elapsed ticks.
  int m_ph, m_intro_el, m_fight_t, m_res_el, m_timer, m_s1, m_s2, m_round, m_win;
  int m_f_held, m_c_held;
  bit m_f_lock, m_c_lock, m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_restart_values();
    m_ph = 0; m_intro_el = 0; m_fight_t = 0; m_res_el = 0; m_timer = SECS;
    m_s1 = 0; m_s2 = 0; m_round = 1; m_win = 0; m_f_held = 0; m_c_held = 0;
  endtask

  task automatic model_end_round(input int w);
    m_win = w;
    if (w == 1) m_s1++;
    if (w == 2) m_s2++;
    m_ph = 2;
    m_res_el = 0;
  endtask

  task automatic model_step(input bit te);
    bit pulse;
    int h1, h2;
    pulse = 0;
    h1 = int'(bus.health_1);
    h2 = int'(bus.health_2);
    if (te) begin
      if (!bus.force_reset_sw) begin m_f_held = 0; m_f_lock = 0; end
      else if (!m_f_lock && m_f_held < HOLD) m_f_held++;
      if (!bus.confirm_btn) begin m_c_held = 0; m_c_lock = 0; end
      else if (m_ph != 3) m_c_held = 0;
      else if (!m_c_lock && m_c_held < HOLD) m_c_held++;

      if (m_f_held == HOLD || (m_ph == 3 && m_c_held == HOLD)) begin
        model_restart_values();
        m_f_lock = bus.force_reset_sw;
        m_c_lock = bus.confirm_btn;
        pulse = 1;
      end else if (m_ph == 0) begin
        m_intro_el++;
        if (m_intro_el == READY) begin m_ph = 1; m_fight_t = 0; m_timer = SECS; end
      end else if (m_ph == 1) begin
        if (h1 == 0 && h2 == 0) model_end_round(3);
        else if (h1 == 0) model_end_round(2);
        else if (h2 == 0) model_end_round(1);
        else begin
          m_fight_t++;
          m_timer = SECS - m_fight_t / HZ;
          if (m_fight_t == SECS * HZ)
            model_end_round(h1 > h2 ? 1 : (h2 > h1 ? 2 : 3));
        end
      end else if (m_ph == 2) begin
        m_res_el++;
        if (m_res_el == RESULT) begin
          if (m_s1 == R_WIN || m_s2 == R_WIN) begin
            m_ph = 3;
            m_win = (m_s1 == R_WIN) ? 1 : 2;
          end else begin
            m_ph = 0; m_intro_el = 0; m_win = 0;
            m_round = (m_round < 15) ? m_round + 1 : 15;
            pulse = 1;
          end
        end
      end
    end
    m_rr = pulse && !m_rr;
  endtask

  task automatic check_all();
    chk("state_dbg",     32'(bus.state_dbg),     32'(m_ph));
    chk("inputs_enable", 32'(bus.inputs_enable), 32'(m_ph == 1));
    chk("round_reset",   32'(bus.round_reset),   32'(m_rr));
    chk("round_num",     32'(bus.round_num),     32'(m_round));
    chk("timer_secs",    32'(bus.timer_secs),    32'(m_timer));
    chk("score_1",       32'(bus.score_1),       32'(m_s1));
    chk("score_2",       32'(bus.score_2),       32'(m_s2));
    chk("winner",        32'(bus.winner),        32'(m_win));
    chk("match_over",    32'(bus.match_over),    32'(m_ph == 3));
  endtask

  task automatic cyc(input bit te);
    bus.tick_en = te;
    @(posedge clk);
    model_step(te);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.tick_en = 1'b0;
    @(posedge clk);
    model_restart_values();
    m_f_lock = 0; m_c_lock = 0; m_rr = 0;
    #1;
    reset = 1'b0;
    check_all();
  endtask

  task automatic set_hp(input int a, input int b);
    bus.health_1 = HP_W'(a);
    bus.health_2 = HP_W'(b);
  endtask

  initial begin
    bit conf, frc;
    bus.tick_en = 1'b0;
    bus.confirm_btn = 1'b0;
    bus.force_reset_sw = 1'b0;
    set_hp(100, 100);
    m_rr = 0;
    do_reset();
    chk("reset_state", 32'(bus.state_dbg), 0);
    chk("reset_timer", 32'(bus.timer_secs), 60);
    chk("reset_round", 32'(bus.round_num), 1);

    // Intro countdown: FIGHT on tick 60.
    ticks(59);
    chk("intro_59", 32'(bus.state_dbg), 0);
    ticks(1);
    chk("fight_entry", 32'(bus.state_dbg), 1);
    chk("fight_ien", 32'(bus.inputs_enable), 1);
    chk("fight_timer", 32'(bus.timer_secs), 60);

    // P2 knocked out: P1 takes round 1.
    set_hp(100, 0);
    ticks(1);
    chk("ko_winner", 32'(bus.winner), 1);
    chk("ko_score1", 32'(bus.score_1), 1);
    chk("ko_state", 32'(bus.state_dbg), 2);
    set_hp(100, 100);
    ticks(39);
    chk("result_39", 32'(bus.state_dbg), 2);
    ticks(1);
    chk("round2_state", 32'(bus.state_dbg), 0);
    chk("round2_num", 32'(bus.round_num), 2);
    chk("round2_pulse", 32'(bus.round_reset), 1);
    cyc(1'b0);
    chk("round2_pulse_end", 32'(bus.round_reset), 0);

    // Double KO draw.
    ticks(60);
    set_hp(0, 0);
    ticks(1);
    chk("draw_winner", 32'(bus.winner), 3);
    chk("draw_score1", 32'(bus.score_1), 1);
    chk("draw_score2", 32'(bus.score_2), 0);
    set_hp(100, 100);
    ticks(40);
    chk("draw_round3", 32'(bus.round_num), 3);
    chk("draw_no_mo", 32'(bus.match_over), 0);

    // Full-length round decided on time.
    ticks(60);
    set_hp(50, 80);
    ticks(1199);
    chk("to_timer1", 32'(bus.timer_secs), 1);
    chk("to_still_fight", 32'(bus.state_dbg), 1);
    ticks(1);
    chk("to_timer0", 32'(bus.timer_secs), 0);
    chk("to_winner", 32'(bus.winner), 2);
    chk("to_score2", 32'(bus.score_2), 1);
    set_hp(100, 100);
    ticks(40);

    // Second P1 round win ends the match.
    ticks(60);
    set_hp(100, 0);
    ticks(1);
    set_hp(100, 100);
    ticks(40);
    chk("mo_state", 32'(bus.state_dbg), 3);
    chk("mo_winner", 32'(bus.winner), 1);
    chk("mo_flag", 32'(bus.match_over), 1);

    // Confirm held one tick short, then held long enough.
    bus.confirm_btn = 1'b1;
    ticks(39);
    bus.confirm_btn = 1'b0;
    ticks(1);
    chk("confirm_short", 32'(bus.state_dbg), 3);
    bus.confirm_btn = 1'b1;
    ticks(39);
    chk("confirm_39", 32'(bus.state_dbg), 3);
    ticks(1);
    chk("confirm_state", 32'(bus.state_dbg), 0);
    chk("confirm_score1", 32'(bus.score_1), 0);
    chk("confirm_round", 32'(bus.round_num), 1);
    chk("confirm_pulse", 32'(bus.round_reset), 1);
    ticks(5);
    bus.confirm_btn = 1'b0;

    // Force restart mid-fight, KO on the same final tick.
    ticks(60);
    set_hp(100, 0);
    ticks(1);
    set_hp(100, 100);
    ticks(40 + 60);
    chk("pre_force_score1", 32'(bus.score_1), 1);
    bus.force_reset_sw = 1'b1;
    ticks(39);
    set_hp(100, 0);
    ticks(1);
    chk("force_state", 32'(bus.state_dbg), 0);
    chk("force_score1", 32'(bus.score_1), 0);
    chk("force_winner", 32'(bus.winner), 0);
    chk("force_pulse", 32'(bus.round_reset), 1);
    set_hp(100, 100);
    ticks(45);
    chk("force_no_repeat", 32'(bus.state_dbg), 0);
    bus.force_reset_sw = 1'b0;

    // Synchronous reset mid-fight produces no round_reset pulse.
    ticks(70);
    do_reset();
    chk("sync_rst_pulse", 32'(bus.round_reset), 0);
    chk("sync_rst_state", 32'(bus.state_dbg), 0);

    // Random play with sparse ticks, KOs, and button bursts.
    conf = 0;
    frc = 0;
    for (int i = 0; i < 40000; i++) begin
      set_hp(($urandom_range(0, 249) == 0) ? 0 : int'($urandom_range(1, 300)),
             ($urandom_range(0, 249) == 0) ? 0 : int'($urandom_range(1, 300)));
      if ($urandom_range(0, 49) == 0) conf = ~conf;
      if (frc) begin
        if ($urandom_range(0, 59) == 0) frc = 0;
      end else if ($urandom_range(0, 799) == 0) begin
        frc = 1;
      end
      bus.confirm_btn = conf;
      bus.force_reset_sw = frc;
      cyc($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
